// File: rtl/alarm_ctrl.sv
// Alarm-time register with BCD digit editor, key synchronisers and ring/silence logic.
// Define ALARM_BEEP_EN to pulse ring from bit 23 of a free-running counter; otherwise ring is steady.
module alarm_ctrl #(
  parameter logic [5:0] ALARM_HOUR_INIT = 6'h07,
  parameter logic [6:0] ALARM_MIN_INIT  = 7'h00
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_next_n,
  input  logic       key_inc_n,
  input  logic       key_alarm_n,
  input  logic [5:0] cur_hour,
  input  logic [6:0] cur_minute,
  output logic       state,
  output logic [3:0] select_one,
  output logic [5:0] alarm_hour,
  output logic [6:0] alarm_minute,
  output logic       ring
);

  localparam int K_MODE  = 0;
  localparam int K_NEXT  = 1;
  localparam int K_INC   = 2;
  localparam int K_ALARM = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_ML = 3'd1,
    SET_MH = 3'd2,
    SET_HL = 3'd3,
    SET_HH = 3'd4
  } fsm_t;

  logic [3:0] keys_n;
  logic [3:0] press;
  logic [1:0] settle_reg;

  assign keys_n = {key_alarm_n, key_inc_n, key_next_n, key_mode_n};

  // settle_reg[1] marks that the synchroniser outputs hold real samples since reset
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      settle_reg <= 2'b00;
    end else begin
      settle_reg <= {settle_reg[0], 1'b1};
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      logic sync1_reg;
      logic sync2_reg;
      logic edge_reg;
      logic armed_reg;

      // A key held through reset stays disarmed until it is seen released once
      always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          edge_reg  <= 1'b1;
          armed_reg <= 1'b0;
        end else begin
          sync1_reg <= keys_n[gi];
          sync2_reg <= sync1_reg;
          edge_reg  <= sync2_reg;
          armed_reg <= armed_reg | (settle_reg[1] & sync2_reg);
        end
      end

      assign press[gi] = armed_reg & edge_reg & ~sync2_reg;
    end
  endgenerate

  fsm_t       fsm_reg, fsm_next;
  logic       state_reg, state_next;
  logic [3:0] sel_reg, sel_next;
  logic [5:0] hour_reg, hour_next;
  logic [6:0] min_reg, min_next;
  logic       silenced_reg, silenced_next;
  logic       ring_base_reg, ring_base_next;

  logic       match;
  logic       silence_hit;
  logic       alarm_off;
  logic [1:0] hour_tens_inc;
  logic [3:0] hour_units_top;

  assign match = state_reg & (fsm_reg == IDLE) &
                 (hour_reg == cur_hour) & (min_reg == cur_minute);
  assign silence_hit    = ring_base_reg & (|press);
  assign hour_tens_inc  = (hour_reg[5:4] >= 2'd2) ? 2'd0 : hour_reg[5:4] + 2'd1;
  assign hour_units_top = (hour_reg[5:4] == 2'd2) ? 4'd3 : 4'd9;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= IDLE;
      state_reg     <= 1'b0;
      sel_reg       <= 4'b0000;
      hour_reg      <= ALARM_HOUR_INIT;
      min_reg       <= ALARM_MIN_INIT;
      silenced_reg  <= 1'b0;
      ring_base_reg <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      hour_reg      <= hour_next;
      min_reg       <= min_next;
      silenced_reg  <= silenced_next;
      ring_base_reg <= ring_base_next;
    end
  end

  always_comb begin
    fsm_next      = fsm_reg;
    state_next    = state_reg;
    hour_next     = hour_reg;
    min_next      = min_reg;
    silenced_next = silenced_reg;
    alarm_off     = 1'b0;

    if (silence_hit) begin
      // the silencing press is consumed entirely
      silenced_next = 1'b1;
    end else begin
      if (press[K_ALARM]) begin
        state_next = ~state_reg;
        alarm_off  = state_reg;
      end

      if (press[K_MODE]) begin
        fsm_next = (fsm_reg == IDLE) ? SET_ML : IDLE;
      end else if (press[K_NEXT]) begin
        case (fsm_reg)
          SET_ML:  fsm_next = SET_MH;
          SET_MH:  fsm_next = SET_HL;
          SET_HL:  fsm_next = SET_HH;
          SET_HH:  fsm_next = SET_ML;
          default: fsm_next = fsm_reg;
        endcase
      end else if (press[K_INC]) begin
        case (fsm_reg)
          SET_ML: min_next[3:0] = (min_reg[3:0] >= 4'd9) ? 4'd0 : min_reg[3:0] + 4'd1;
          SET_MH: min_next[6:4] = (min_reg[6:4] >= 3'd5) ? 3'd0 : min_reg[6:4] + 3'd1;
          SET_HL: hour_next[3:0] = (hour_reg[3:0] >= hour_units_top) ? 4'd0
                                                                     : hour_reg[3:0] + 4'd1;
          SET_HH: begin
            hour_next[5:4] = hour_tens_inc;
            if (hour_tens_inc == 2'd2 && hour_reg[3:0] > 4'd3) begin
              hour_next[3:0] = 4'd3;
            end
          end
          default: ;
        endcase
      end
    end

    if (!match || alarm_off) begin
      silenced_next = 1'b0;
    end

    ring_base_next = match & ~silenced_next & ~alarm_off;

    case (fsm_next)
      SET_ML:  sel_next = 4'b0001;
      SET_MH:  sel_next = 4'b0010;
      SET_HL:  sel_next = 4'b0100;
      SET_HH:  sel_next = 4'b1000;
      default: sel_next = 4'b0000;
    endcase
  end

`ifdef ALARM_BEEP_EN
  logic [23:0] beep_cnt_reg;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      beep_cnt_reg <= 24'd0;
    end else begin
      beep_cnt_reg <= beep_cnt_reg + 24'd1;
    end
  end

  assign ring = ring_base_reg & beep_cnt_reg[23];
`else
  assign ring = ring_base_reg;
`endif

  assign state        = state_reg;
  assign select_one   = sel_reg;
  assign alarm_hour   = hour_reg;
  assign alarm_minute = min_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: stimulus queues expected snapshots, a negedge monitor compares them.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] keys_n = 4'hF;
  logic [5:0] cur_hour = 6'h00;
  logic [6:0] cur_minute = 7'h00;
  logic       state;
  logic [3:0] select_one;
  logic [5:0] alarm_hour;
  logic [6:0] alarm_minute;
  logic       ring;

  localparam logic [3:0] KM = 4'b0001;
  localparam logic [3:0] KN = 4'b0010;
  localparam logic [3:0] KI = 4'b0100;
  localparam logic [3:0] KA = 4'b1000;

  alarm_ctrl dut (
    .CLOCK_50     (clk),
    .rst_n        (rst_n),
    .key_mode_n   (keys_n[0]),
    .key_next_n   (keys_n[1]),
    .key_inc_n    (keys_n[2]),
    .key_alarm_n  (keys_n[3]),
    .cur_hour     (cur_hour),
    .cur_minute   (cur_minute),
    .state        (state),
    .select_one   (select_one),
    .alarm_hour   (alarm_hour),
    .alarm_minute (alarm_minute),
    .ring         (ring)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       nm;
    logic [18:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  logic       e_st;
  logic [3:0] e_sel;
  logic [5:0] e_hr;
  logic [6:0] e_mn;
  logic       e_rg;

  function automatic void push(input int due, input string nm, input logic [18:0] v);
    sb_t t;
    t.due = due;
    t.nm  = nm;
    t.exp = v;
    sb.push_back(t);
  endfunction

  always @(negedge clk) begin
    sb_t e;
    logic [18:0] got;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      got = {state, select_one, alarm_hour, alarm_minute, ring};
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: sample slot %0d missed, now %0d", e.nm, e.due, cyc);
      end else if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got st=%b sel=%b %h:%h ring=%b, required st=%b sel=%b %h:%h ring=%b",
                 e.nm, got[18], got[17:14], got[13:8], got[7:1], got[0],
                 e.exp[18], e.exp[17:14], e.exp[13:8], e.exp[7:1], e.exp[0]);
      end else begin
        $display("ok   %-20s cyc=%0d st=%b sel=%b %h:%h ring=%b",
                 e.nm, cyc, got[18], got[17:14], got[13:8], got[7:1], got[0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_reset_expect();
    e_st = 1'b0; e_sel = 4'b0000; e_hr = 6'h07; e_mn = 7'h00; e_rg = 1'b0;
  endtask

  // One press: old value one edge before the action edge, new value on it, and ring rg4 one edge later.
  task automatic press(input logic [3:0] mask, input string nm, input logic st,
                       input logic [3:0] sel, input logic [5:0] hr, input logic [6:0] mn,
                       input logic rg, input logic rg4, input int hold);
    int c;
    c = cyc;
    push(c + 2, {nm, "_pre"}, {e_st, e_sel, e_hr, e_mn, e_rg});
    push(c + 3, nm, {st, sel, hr, mn, rg});
    push(c + 4 + hold, {nm, "_post"}, {st, sel, hr, mn, rg4});
    keys_n = keys_n & ~mask;
    step(3 + hold);
    keys_n = keys_n | mask;
    step(3);
    e_st = st; e_sel = sel; e_hr = hr; e_mn = mn; e_rg = rg4;
  endtask

  task automatic set_time(input logic [5:0] hr, input logic [6:0] mn, input logic rg,
                          input string nm);
    push(cyc, {nm, "_pre"}, {e_st, e_sel, e_hr, e_mn, e_rg});
    push(cyc + 1, nm, {e_st, e_sel, e_hr, e_mn, rg});
    cur_hour = hr;
    cur_minute = mn;
    step(2);
    e_rg = rg;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    push(cyc, nm, {1'b0, 4'b0000, 6'h07, 7'h00, 1'b0});
    step(2);
    rst_n = 1'b1;
    step(5);
    set_reset_expect();
  endtask

  logic [3:0] next_sel [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    step(2);
    push(cyc, "reset_hold", {1'b0, 4'b0000, 6'h07, 7'h00, 1'b0});
    step(1);
    rst_n = 1'b1;
    step(5);
    set_reset_expect();

    // select sequencing with a long hold on the first press
    press(KM, "mode_ml", 0, 4'b0001, 6'h07, 7'h00, 0, 0, 8);
    for (int i = 0; i < 4; i++)
      press(KN, $sformatf("next%0d", i), 0, next_sel[i], 6'h07, 7'h00, 0, 0, 0);
    press(KM, "mode_idle", 0, 4'b0000, 6'h07, 7'h00, 0, 0, 0);
    press(KN, "next_idle_ign", 0, 4'b0000, 6'h07, 7'h00, 0, 0, 0);
    press(KI, "inc_idle_ign", 0, 4'b0000, 6'h07, 7'h00, 0, 0, 0);

    // build 19:59
    press(KM, "b_mode", 0, 4'b0001, 6'h07, 7'h00, 0, 0, 0);
    press(KN, "b_mh", 0, 4'b0010, 6'h07, 7'h00, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      press(KI, $sformatf("b_mt%0d", i), 0, 4'b0010, 6'h07, 7'(i << 4), 0, 0, 0);
    press(KN, "b_hl", 0, 4'b0100, 6'h07, 7'h50, 0, 0, 0);
    press(KI, "b_hu8", 0, 4'b0100, 6'h08, 7'h50, 0, 0, 0);
    press(KI, "b_hu9", 0, 4'b0100, 6'h09, 7'h50, 0, 0, 0);
    press(KN, "b_hh", 0, 4'b1000, 6'h09, 7'h50, 0, 0, 0);
    press(KI, "b_ht1", 0, 4'b1000, 6'h19, 7'h50, 0, 0, 0);
    press(KN, "b_ml", 0, 4'b0001, 6'h19, 7'h50, 0, 0, 0);
    for (int i = 1; i <= 9; i++)
      press(KI, $sformatf("b_mu%0d", i), 0, 4'b0001, 6'h19, 7'h50 + 7'(i), 0, 0, 0);

    // digit wrap and clamp
    press(KN, "w_mh", 0, 4'b0010, 6'h19, 7'h59, 0, 0, 0);
    press(KN, "w_hl", 0, 4'b0100, 6'h19, 7'h59, 0, 0, 0);
    press(KN, "w_hh", 0, 4'b1000, 6'h19, 7'h59, 0, 0, 0);
    press(KI, "hh_clamp", 0, 4'b1000, 6'h23, 7'h59, 0, 0, 0);
    press(KN, "w_ml", 0, 4'b0001, 6'h23, 7'h59, 0, 0, 0);
    press(KN, "w_mh2", 0, 4'b0010, 6'h23, 7'h59, 0, 0, 0);
    press(KN, "w_hl2", 0, 4'b0100, 6'h23, 7'h59, 0, 0, 0);
    press(KI, "hl_wrap", 0, 4'b0100, 6'h20, 7'h59, 0, 0, 0);
    press(KN, "w_hh2", 0, 4'b1000, 6'h20, 7'h59, 0, 0, 0);
    press(KN, "w_ml2", 0, 4'b0001, 6'h20, 7'h59, 0, 0, 0);
    press(KI, "ml_wrap", 0, 4'b0001, 6'h20, 7'h50, 0, 0, 0);
    press(KN, "w_mh3", 0, 4'b0010, 6'h20, 7'h50, 0, 0, 0);
    press(KI, "mh_wrap", 0, 4'b0010, 6'h20, 7'h00, 0, 0, 0);
    press(KN, "w_hl3", 0, 4'b0100, 6'h20, 7'h00, 0, 0, 0);
    press(KN, "w_hh3", 0, 4'b1000, 6'h20, 7'h00, 0, 0, 0);
    press(KI, "hh_wrap", 0, 4'b1000, 6'h00, 7'h00, 0, 0, 0);

    do_reset("reset_mid_edit");

    // key held across reset release must not act
    keys_n = keys_n & ~KM;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(6);
    push(cyc, "held_no_action", {1'b0, 4'b0000, 6'h07, 7'h00, 1'b0});
    step(1);
    keys_n = keys_n | KM;
    step(4);

    press(KM | KI, "mode_inc_same", 0, 4'b0001, 6'h07, 7'h00, 0, 0, 0);
    press(KM, "mode_idle2", 0, 4'b0000, 6'h07, 7'h00, 0, 0, 0);

    // ring, silence and re-fire
    press(KA, "arm", 1, 4'b0000, 6'h07, 7'h00, 0, 0, 0);
    set_time(6'h07, 7'h00, 1, "match_ring");
    set_time(6'h07, 7'h01, 0, "minute_past");
    set_time(6'h07, 7'h00, 1, "match_again");
    press(KI, "silence_inc", 1, 4'b0000, 6'h07, 7'h00, 0, 0, 0);
    set_time(6'h07, 7'h01, 0, "silence_clear");
    set_time(6'h07, 7'h00, 1, "refire");
    press(KA, "silence_alarm", 1, 4'b0000, 6'h07, 7'h00, 0, 0, 0);
    press(KA, "alarm_off", 0, 4'b0000, 6'h07, 7'h00, 0, 0, 0);
    press(KA, "alarm_on", 1, 4'b0000, 6'h07, 7'h00, 0, 1, 0);
    press(KM, "silence_mode", 1, 4'b0000, 6'h07, 7'h00, 0, 0, 0);
    set_time(6'h07, 7'h01, 0, "leave_minute");
    press(KM, "edit_enter", 1, 4'b0001, 6'h07, 7'h00, 0, 0, 0);
    set_time(6'h07, 7'h00, 0, "edit_no_ring");
    press(KM, "edit_leave", 1, 4'b0000, 6'h07, 7'h00, 0, 1, 0);

    do_reset("reset_ringing");
    step(3);

    while (sb.size() > 0) begin
      sb_t t;
      t = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never sampled, slot %0d", t.nm, t.due);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
